// File: rtl/ysyx_25040129_ifu_if.sv
// ==[ ysyx_25040129_ifu_if : AXI4-Lite-style instruction read channels (AR + R) ]== rev 1.0
`default_nettype none

interface ysyx_25040129_ifu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25040129_ifu.sv
// ==[ ysyx_25040129_ifu : fetch PC owner, one outstanding read, redirect/kill handling ]== rev 1.0
// ==[ optional bus-error reporting via macro YSYX_25040129_IFU_FAULT_EN ]==
`default_nettype none

module ysyx_25040129_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_25040129_ifu_if.master        bus,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [31:0]                inst_out_ifu,
  output logic [31:0]                pc_out_ifu,
  output logic                       is_req_valid_to_idu,
  input  logic                       is_req_ready_from_idu
`ifdef YSYX_25040129_IFU_FAULT_EN
  ,
  output logic                       fetch_fault_out_ifu
`endif
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        kill_q, kill_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] redirect_tgt;
  logic [31:0] resp_inst;

  assign redirect_tgt = redirect_pc & ~32'h3;

`ifdef YSYX_25040129_IFU_FAULT_EN
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  logic fault_q, fault_d;
  logic resp_err;
  assign resp_err  = (bus.rresp != 2'b00);
  assign resp_inst = resp_err ? NOP_INST : bus.rdata;
`else
  logic unused_rresp;
  assign unused_rresp = ^bus.rresp;
  assign resp_inst    = bus.rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      fetch_pc_q   <= RESET_PC;
      hold_inst_q  <= 32'h0;
      hold_pc_q    <= 32'h0;
      kill_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
`ifdef YSYX_25040129_IFU_FAULT_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      kill_q       <= kill_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
`ifdef YSYX_25040129_IFU_FAULT_EN
      fault_q      <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    kill_d       = kill_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
`ifdef YSYX_25040129_IFU_FAULT_EN
    fault_d      = fault_q;
`endif
    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        // araddr must stay put until accepted, so a redirect is parked and the read killed later
        if (redirect_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_tgt;
        end
        if (bus.arready) begin
          state_d = S_WAIT;
          kill_d  = pend_valid_q | redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.rvalid) begin
          if (kill_q | redirect_valid) begin
            state_d      = S_REQ;
            fetch_pc_d   = redirect_valid ? redirect_tgt : pend_pc_q;
            kill_d       = 1'b0;
            pend_valid_d = 1'b0;
          end else begin
            state_d     = S_HOLD;
            hold_inst_d = resp_inst;
            hold_pc_d   = fetch_pc_q;
`ifdef YSYX_25040129_IFU_FAULT_EN
            fault_d     = resp_err;
`endif
          end
        end else if (redirect_valid) begin
          kill_d       = 1'b1;
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_tgt;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect_tgt;
        end else if (is_req_ready_from_idu) begin
          state_d    = S_REQ;
          fetch_pc_d = hold_pc_q + 32'd4;
        end
`ifdef YSYX_25040129_IFU_FAULT_EN
        if (redirect_valid || is_req_ready_from_idu) fault_d = 1'b0;
`endif
      end
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    bus.araddr          = fetch_pc_q;
    bus.arvalid         = (state_q == S_REQ);
    bus.rready          = (state_q == S_WAIT);
    // redirect beats a same-cycle decode handshake
    is_req_valid_to_idu = (state_q == S_HOLD) && !redirect_valid;
    inst_out_ifu        = hold_inst_q;
    pc_out_ifu          = hold_pc_q;
`ifdef YSYX_25040129_IFU_FAULT_EN
    fetch_fault_out_ifu = fault_q;
`endif
  end

endmodule

`default_nettype wire
